// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply / 32/32 divide with HI/LO registers.
// MULTU/MULT use shift-add, DIVU/DIV use restoring division, one bit per cycle.
// Latency is 33 cycles from the start edge to HI/LO visible.
// Optional feature macro: MULDIV_SIGNED_EN
//   defined     : op[0]=1 selects signed MULT/DIV with magnitude conversion
//                 and sign correction of the results.
//   not defined : op[0] is ignored and every operation is unsigned.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; MTHI/MTLO writes accepted
// S_CALC | 32 iterations, one multiplier/quotient bit per cycle
// S_DONE | sign correction, HI/LO and dz written, done pulses next cycle

module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        dz,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [63:0] acc;      // multiply: {partial product, multiplier}; divide: {remainder, quotient}
    logic [31:0] opnd;     // multiplicand or divisor magnitude
    logic        is_div;

    logic [31:0] mag_a;
    logic [31:0] mag_b;

    // Per-iteration datapath terms.
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [33:0] div_diff;

    // Results after optional sign correction.
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic        div_zero;

`ifdef MULDIV_SIGNED_EN
    logic signed_op;
    logic neg_a_in;
    logic neg_b_in;
    logic neg_q;           // negate product or quotient
    logic neg_r;           // negate remainder (follows dividend sign)

    assign signed_op = op[0];
    assign neg_a_in  = signed_op & a[31];
    assign neg_b_in  = signed_op & b[31];
    assign mag_a     = neg_a_in ? (~a + 32'd1) : a;
    assign mag_b     = neg_b_in ? (~b + 32'd1) : b;

    // Result signs are captured together with the operands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == S_IDLE && start) begin
            neg_q <= neg_a_in ^ neg_b_in;
            neg_r <= neg_a_in;
        end
    end

    assign prod_fix = neg_q ? (~acc + 64'd1) : acc;
    assign quot_fix = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
    assign rem_fix  = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
`else
    logic unused_op0;

    assign unused_op0 = op[0];
    assign mag_a      = a;
    assign mag_b      = b;
    assign prod_fix   = acc;
    assign quot_fix   = acc[31:0];
    assign rem_fix    = acc[63:32];
`endif

    assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    assign div_shift = {acc[63:32], acc[31]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    assign div_zero  = (opnd == 32'd0);

    assign busy = (state != S_IDLE);

    // Sequencer: IDLE -> CALC (32 cycles) -> DONE -> IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= 5'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_CALC;
                        cnt   <= 5'd0;
                    end
                end
                S_CALC: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 5'd0;
                end
            endcase
        end
    end

    // Operand capture and one shift-add or restoring-divide step per CALC cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc    <= 64'd0;
            opnd   <= 32'd0;
            is_div <= 1'b0;
        end else if (state == S_IDLE) begin
            if (start) begin
                is_div <= op[1];
                if (op[1]) begin
                    acc  <= {32'd0, mag_a};
                    opnd <= mag_b;
                end else begin
                    acc  <= {32'd0, mag_b};
                    opnd <= mag_a;
                end
            end
        end else if (state == S_CALC) begin
            if (!is_div) begin
                acc <= {mul_sum, acc[31:1]};
            end else if (!div_diff[33]) begin
                acc <= {div_diff[31:0], acc[30:0], 1'b1};
            end else begin
                acc <= {div_shift[31:0], acc[30:0], 1'b0};
            end
        end
    end

    // HI/LO: MTHI/MTLO in IDLE, operation results in DONE; zero divisor leaves them alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (state == S_IDLE) begin
            if (hi_we) begin
                hi <= wdata;
            end
            if (lo_we) begin
                lo <= wdata;
            end
        end else if (state == S_DONE) begin
            if (!is_div) begin
                hi <= prod_fix[63:32];
                lo <= prod_fix[31:0];
            end else if (!div_zero) begin
                hi <= rem_fix;
                lo <= quot_fix;
            end
        end
    end

    // done and dz pulse for the single cycle after DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done <= 1'b0;
            dz   <= 1'b0;
        end else begin
            done <= (state == S_DONE);
            dz   <= (state == S_DONE) && is_div && div_zero;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed sequence with a result scoreboard.
// Expected HI/LO come from plain 64-bit SystemVerilog arithmetic.

module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct packed {
        logic        dz;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] cur_hi, input logic [31:0] cur_lo);
        exp_t r;
        logic sgn;
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic signed [63:0] res;
`ifdef MULDIV_SIGNED_EN
        sgn = o[0];
`else
        sgn = 1'b0;
`endif
        sx = sgn ? {{32{x[31]}}, x} : {32'd0, x};
        sy = sgn ? {{32{y[31]}}, y} : {32'd0, y};
        r.dz = 1'b0;
        if (!o[1]) begin
            res  = sx * sy;
            r.hi = res[63:32];
            r.lo = res[31:0];
        end else if (y == 32'd0) begin
            r.dz = 1'b1;
            r.hi = cur_hi;
            r.lo = cur_lo;
        end else begin
            res  = sx / sy;
            r.lo = res[31:0];
            res  = sx % sy;
            r.hi = res[31:0];
        end
        return r;
    endfunction

    // Called at a negedge: drive start for one edge and queue the expected result.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        sb.push_back(model(o, x, y, m_hi, m_lo));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge after the start edge; returns at the negedge where done=1.
    task automatic check_op(input string tag);
        int   n;
        int   busy_cnt;
        exp_t e;
        n        = 0;
        busy_cnt = 0;
        while (!done && n < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd33);
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, "_sb_depth"}, 64'(sb.size()), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
            chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
            chk({tag, "_dz"}, 64'(dz), 64'(e.dz));
            m_hi = e.hi;
            m_lo = e.lo;
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = 2'd0;
        a     = 32'd0;
        b     = 32'd0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = 32'd0;
        #1;
        chk("rst_hi",   64'(hi),   64'd0);
        chk("rst_lo",   64'(lo),   64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dz",   64'(dz),   64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        @(negedge clk); issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF); check_op("multu_max");
        chk("multu_max_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        @(negedge clk); issue(2'b01, 32'hFFFF_FFFD, 32'd5);         check_op("mult_neg");
        @(negedge clk); issue(2'b11, 32'hFFFF_FFF9, 32'd2);         check_op("div_neg");
        @(negedge clk); issue(2'b10, 32'd7, 32'd2);                 check_op("divu_7_2");
        chk("divu_7_2_lo_const", 64'(lo), 64'd3);

        // MTHI then divide by zero
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0;
        m_hi  = 32'h1234_5678;
        chk("mthi_hi", 64'(hi), 64'h1234_5678);
        issue(2'b10, 32'd9, 32'd0); check_op("divu_by_zero");
        chk("divu_by_zero_hi_const", 64'(hi), 64'h1234_5678);
        @(negedge clk);
        chk("dz_clears", 64'(dz), 64'd0);

        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF); check_op("div_ovf");
        @(negedge clk); issue(2'b11, 32'd100, 32'hFFFF_FFF9);       check_op("div_neg_divisor");

        // MTLO in the same IDLE cycle as start: the result wins
        @(negedge clk);
        lo_we = 1'b1;
        wdata = 32'hCAFE_F00D;
        issue(2'b00, 32'd11, 32'd13);
        lo_we = 1'b0;
        chk("mtlo_with_start", 64'(lo), 64'hCAFE_F00D);
        check_op("mtlo_then_mul");

        // Ignored start/hi_we mid-operation, then reset abort
        @(negedge clk);
        issue(2'b00, 32'd123, 32'd456);
        repeat (4) @(negedge clk);
        start = 1'b1;
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        a     = 32'd1;
        b     = 32'd1;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        chk("ignored_busy", 64'(busy), 64'd1);
        chk("ignored_hi_we", 64'(hi), 64'(m_hi));
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_hi",   64'(hi),   64'd0);
        chk("abort_lo",   64'(lo),   64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        if (sb.size() != 0) void'(sb.pop_front());
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); issue(2'b00, 32'd6, 32'd7); check_op("after_abort");
        chk("after_abort_lo_const", 64'(lo), 64'd42);

        // Back-to-back: start issued in the done cycle
        @(negedge clk); issue(2'b11, 32'hFFFF_FF9C, 32'd7); check_op("b2b_first");
        issue(2'b00, 32'd2, 32'd3); check_op("b2b_second");
        chk("b2b_second_lo_const", 64'(lo), 64'd6);

        for (int i = 0; i < 6; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            issue(ro, ra, rb);
            check_op("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
